// File: rtl/uart_reg_bus_if.sv
// CPU-side responder for the UART register bank: req/gnt/rvalid handshake,
// one-hot register strobes and error-flagged read/write responses.
module uart_reg_bus_if #(
   parameter int unsigned NUM_REGS   = 4,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 6
) (
   input  logic                           clk_i,
   input  logic                           rst_ni,
   input  logic                           req_i,
   input  logic                           we_i,
   input  logic [ADDR_WIDTH-1:0]          addr_i,
   input  logic [DATA_WIDTH-1:0]          wdata_i,
   output logic                           gnt_o,
   output logic                           rvalid_o,
   output logic [DATA_WIDTH-1:0]          rdata_o,
   output logic                           err_o,
   output logic [NUM_REGS-1:0]            reg_wr_en_o,
   output logic [NUM_REGS-1:0]            reg_rd_en_o,
   output logic [DATA_WIDTH-1:0]          reg_wdata_o,
   input  logic [NUM_REGS*DATA_WIDTH-1:0] reg_rdata_i
);

   localparam int unsigned IDX_W = ADDR_WIDTH - 2;

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      RESP
   } state_t;

   state_t                state, state_next;
   logic                  we_q;
   logic                  err_q;
   logic [IDX_W-1:0]      idx_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [DATA_WIDTH-1:0] rdata_q;

   logic [IDX_W-1:0]      idx_in;
   logic                  err_in;
   logic                  accept;
   logic [NUM_REGS-1:0]   sel;
   logic [DATA_WIDTH-1:0] rd_sel;

   assign idx_in = addr_i[ADDR_WIDTH-1:2];
   assign err_in = (addr_i[1:0] != 2'b00) || (32'(idx_in) >= NUM_REGS);
   // Gated by reset so no grant is offered while the bank is held in reset.
   assign accept = rst_ni && (state == IDLE) && req_i;
   assign gnt_o  = accept;

   always_comb begin
      sel    = '0;
      rd_sel = '0;
      for (int unsigned k = 0; k < NUM_REGS; k++) begin
         if (idx_q == IDX_W'(k)) begin
            sel[k] = 1'b1;
            rd_sel = reg_rdata_i[k*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next  = state;
      rvalid_o    = 1'b0;
      err_o       = 1'b0;
      reg_wr_en_o = '0;
      reg_rd_en_o = '0;
      case (state)
         IDLE: begin
            if (req_i) state_next = ACCESS;
         end
         ACCESS: begin
            state_next = RESP;
            if (!err_q) begin
               if (we_q) reg_wr_en_o = sel;
               else      reg_rd_en_o = sel;
            end
         end
         RESP: begin
            rvalid_o   = 1'b1;
            err_o      = err_q;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         we_q    <= 1'b0;
         err_q   <= 1'b0;
         idx_q   <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         if (accept) begin
            we_q    <= we_i;
            err_q   <= err_in;
            idx_q   <= idx_in;
            wdata_q <= wdata_i;
         end
         // Sampled on the same edge as the read strobe: read-clear bits return pre-clear value.
         if (state == ACCESS) begin
            rdata_q <= (!we_q && !err_q) ? rd_sel : '0;
         end
      end
   end

   assign reg_wdata_o = wdata_q;
   assign rdata_o     = rdata_q;

endmodule
